// File: rtl/resampler_axis_tx.sv
// resampler_axis_tx
//   Output stage of the resampler. Buffers the valid-only sample stream in a
//   first-word-fall-through FIFO and re-emits it as an AXI-Stream master.
//   The output is framed into packets of PKT_LEN beats, with m_tlast_o marking
//   the last beat. A sample that arrives while the FIFO is full is dropped, and
//   the sticky overflow_o flag is set.
//
//   Optional feature (macro RESAMPLER_AXIS_TX_DROP_CNT_EN):
//     adds drop_cnt_o, a 16-bit saturating count of dropped samples.
//
// Ports
//   clk_i       clock
//   rst_i       asynchronous, active-high reset
//   en_i        input-side write enable (the read side ignores it)
//   tvalid_i    input sample valid (no backpressure)
//   tdata_i     input sample; channel k is at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_tvalid_o  AXIS valid
//   m_tready_i  AXIS ready
//   m_tdata_o   AXIS data
//   m_tlast_o   AXIS last (last beat of each packet)
//   clear_i     synchronous clear of overflow_o (and drop_cnt_o)
//   overflow_o  sticky flag: at least one sample was dropped
//   level_o     FIFO occupancy, 0..DEPTH
//   drop_cnt_o  (optional) saturating count of dropped samples
module resampler_axis_tx #(
  parameter int unsigned CH_NUM     = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PKT_LEN    = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         tvalid_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0] tdata_i,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic [CH_NUM*DATA_WIDTH-1:0] m_tdata_o,
  output logic                         m_tlast_o,
  input  logic                         clear_i,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH):0]       level_o
`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt_o
`endif
);

  localparam int unsigned W  = CH_NUM * DATA_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PKT_LEN - 1);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [BW-1:0]   beat_cnt;

  logic            pop;
  logic            push_req;
  logic            accept;
  logic            drop;

  // Valid comes from the registered count only, so it never depends on
  // m_tready_i and an empty FIFO never passes input straight through.
  always_comb begin
    m_tvalid_o = (count != '0);
    m_tdata_o  = mem[rd_ptr];
    m_tlast_o  = m_tvalid_o && (beat_cnt == LAST_BEAT);
    level_o    = count;
  end

  // A full FIFO still accepts a sample when a pop frees a slot on the same edge.
  always_comb begin
    pop      = m_tvalid_o && m_tready_i;
    push_req = tvalid_i && en_i;
    accept   = push_req && ((count < FULL_COUNT) || pop);
    drop     = push_req && !accept;
  end

  // Storage is not reset; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wr_ptr] <= tdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Only pops advance the beat counter, so drops never shorten a packet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // A drop in the same cycle as clear_i takes priority over the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end
  end

`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
  // clear_i together with a drop restarts the count at 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      drop_cnt_o <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_resampler_axis_tx.sv
module tb_resampler_axis_tx;

  localparam int CH    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int PKT   = 4;
  localparam int W     = CH * DW;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          tvalid = 1'b0;
  logic [W-1:0]  tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;
  logic          clear = 1'b0;
  logic          overflow;
  logic [LW-1:0] level;
`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  // Reference model: an ordered queue of accepted samples, a count of beats
  // delivered since reset (tlast when beats mod PKT == PKT-1), sticky flag and
  // saturating drop count.
  logic [W-1:0] mq[$];
  int           beats = 0;
  bit           movf  = 0;
  int           mdrop = 0;

  always #5 clk = ~clk;

  resampler_axis_tx #(
    .CH_NUM    (CH),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .PKT_LEN   (PKT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .tvalid_i  (tvalid),
    .tdata_i   (tdata),
    .m_tvalid_o(m_tvalid),
    .m_tready_i(m_tready),
    .m_tdata_o (m_tdata),
    .m_tlast_o (m_tlast),
    .clear_i   (clear),
    .overflow_o(overflow),
    .level_o   (level)
`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
    ,
    .drop_cnt_o(drop_cnt)
`endif
  );

  task automatic model_reset();
    mq.delete();
    beats = 0;
    movf  = 0;
    mdrop = 0;
  endtask

  // Advance the model by one cycle with the currently driven inputs, then
  // move to 1 time unit after the next rising edge.
  task automatic tick();
    bit pop, req, acc;
    pop = (mq.size() != 0) && m_tready;
    req = tvalid && en;
    acc = req && ((mq.size() < DEPTH) || pop);
    if (pop) begin
      void'(mq.pop_front());
      beats++;
    end
    if (acc) mq.push_back(tdata);
    if (req && !acc) begin
      movf  = 1;
      mdrop = clear ? 1 : ((mdrop < 65535) ? mdrop + 1 : mdrop);
    end else if (clear) begin
      movf  = 0;
      mdrop = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; tvalid = 1'b0; m_tready = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || level !== '0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: valid=%b last=%b level=%0d ovf=%b required all 0",
               m_tvalid, m_tlast, level, overflow);
    end
  endtask

  task automatic test_passthrough();
    logic [W-1:0] exp;
    do_reset();
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tvalid = 1'b1;
      tdata  = {16'(i), 16'(i - 1)};
      exp    = tdata;
      tick();
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== ((i % 4) == 0) || level !== LW'(1)) begin
        failed++;
        $display("FAIL passthrough_beat%0d: valid=%b data=%h last=%b level=%0d required 1 %h %b 1",
                 i, m_tvalid, m_tdata, m_tlast, level, exp, (i % 4) == 0);
      end
    end
    tvalid = 1'b0;
    tick();
    tests++;
    if (m_tvalid !== 1'b0 || level !== '0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL passthrough_end: valid=%b level=%0d ovf=%b required 0 0 0", m_tvalid, level, overflow);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_tready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tvalid = 1'b1;
      tdata  = 32'hA000_0000 + 32'(k);
      tick();
      tests++;
      if (level !== LW'((k < DEPTH) ? k : DEPTH) || overflow !== (k >= 17)) begin
        failed++;
        $display("FAIL fill_sample%0d: level=%0d ovf=%b required %0d %b",
                 k, level, overflow, (k < DEPTH) ? k : DEPTH, k >= 17);
      end
    end
`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 16'd4) begin
      failed++;
      $display("FAIL fill_drop_cnt: got %0d required 4", drop_cnt);
    end
`endif
    tvalid   = 1'b0;
    m_tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'hA000_0000 + 32'(j + 1) || m_tlast !== ((j % 4) == 3)) begin
        failed++;
        $display("FAIL drain_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                 j, m_tvalid, m_tdata, m_tlast, 32'hA000_0000 + 32'(j + 1), (j % 4) == 3);
      end
      tick();
    end
    tests++;
    if (m_tvalid !== 1'b0 || level !== '0) begin
      failed++;
      $display("FAIL drain_empty: valid=%b level=%0d required 0 0", m_tvalid, level);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tvalid = 1'b1;
      tdata  = $urandom;
      tick();
    end
    tdata    = 32'hFEED_BEEF;
    m_tready = 1'b1;
    tick();
    tests++;
    if (level !== LW'(DEPTH) || overflow !== 1'b0) begin
      failed++;
      $display("FAIL full_pop: level=%0d ovf=%b required %0d 0", level, overflow, DEPTH);
    end
    tvalid = 1'b0;
    for (int n = 0; n < 40 && mq.size() != 0; n++) begin
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== mq[0] || m_tlast !== ((beats % PKT) == PKT - 1)) begin
        failed++;
        $display("FAIL full_pop_drain: valid=%b data=%h last=%b required 1 %h %b",
                 m_tvalid, m_tdata, m_tlast, mq[0], (beats % PKT) == PKT - 1);
      end
      tick();
    end
    tests++;
    if (m_tvalid !== 1'b0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL full_pop_end: valid=%b ovf=%b required 0 0", m_tvalid, overflow);
    end
  endtask

  task automatic test_enable_clear();
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tvalid = 1'b1; tdata = $urandom; tick();
      tvalid = 1'b0; tick();
    end
    tests++;
    if (level !== '0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL enable_off: level=%0d ovf=%b required 0 0", level, overflow);
    end
    en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      tvalid = 1'b1; tdata = $urandom; tick();
    end
    clear = 1'b1;
    tick();
    tests++;
    if (overflow !== 1'b1) begin
      failed++;
      $display("FAIL clear_with_drop: ovf=%b required 1", overflow);
    end
`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 16'd1) begin
      failed++;
      $display("FAIL clear_with_drop_cnt: got %0d required 1", drop_cnt);
    end
`endif
    tvalid = 1'b0;
    tick();
    clear = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL clear_alone: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tvalid = 1'b1; tdata = $urandom; tick();
    end
    tvalid   = 1'b0;
    m_tready = 1'b1;
    tick();
    tick();
    m_tready = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || level !== '0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_async: valid=%b last=%b level=%0d ovf=%b required all 0",
               m_tvalid, m_tlast, level, overflow);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tvalid = 1'b1;
      tdata  = 32'h5500_0000 + 32'(i);
      tick();
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h5500_0000 + 32'(i) || m_tlast !== (i == 4)) begin
        failed++;
        $display("FAIL reset_mid_beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                 i, m_tvalid, m_tdata, m_tlast, 32'h5500_0000 + 32'(i), i == 4);
      end
    end
    tvalid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int sent = 0;
    do_reset();
    for (int cyc = 0; cyc < 6000 && (sent < 1000 || mq.size() != 0); cyc++) begin
      tvalid   = (sent < 1000) && ($urandom_range(1, 100) <= 50);
      tdata    = $urandom;
      m_tready = ($urandom_range(1, 100) <= 70);
      clear    = ($urandom_range(1, 100) <= 2);
      if (tvalid) sent++;
      tick();
      tests++;
      if (m_tvalid !== (mq.size() != 0) || level !== LW'(mq.size()) || overflow !== movf ||
          m_tlast !== ((mq.size() != 0) && ((beats % PKT) == PKT - 1)) ||
          (mq.size() != 0 && m_tdata !== mq[0])) begin
        failed++;
        $display("FAIL random_cycle%0d: valid=%b level=%0d ovf=%b last=%b data=%h required %b %0d %b %b %h",
                 cyc, m_tvalid, level, overflow, m_tlast, m_tdata, mq.size() != 0, mq.size(), movf,
                 (mq.size() != 0) && ((beats % PKT) == PKT - 1), (mq.size() != 0) ? mq[0] : '0);
      end
    end
    tests++;
    if (sent != 1000 || mq.size() != 0) begin
      failed++;
      $display("FAIL random_budget: sent=%0d left=%0d required 1000 0", sent, mq.size());
    end
`ifdef RESAMPLER_AXIS_TX_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 16'(mdrop)) begin
      failed++;
      $display("FAIL random_drop_cnt: got %0d required %0d", drop_cnt, mdrop);
    end
`endif
    clear = 1'b0;
    tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_full_pop();
    test_enable_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
